// File: rtl/types_pkg.sv
// Shared types and constants for the immediate packer: width tags, packer
// state encoding and record lengths (payload + 2-bit tag).
package types_pkg;

    typedef enum logic [1:0] {
        NONE      = 2'b00,
        FOURBIT   = 2'b01,
        EIGHTBIT  = 2'b10,
        TWELVEBIT = 2'b11
    } sel_t;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    localparam logic [4:0] REC_LEN_4  = 5'd6;
    localparam logic [4:0] REC_LEN_8  = 5'd10;
    localparam logic [4:0] REC_LEN_12 = 5'd14;
    localparam logic [4:0] REC_LEN_16 = 5'd18;

    localparam int WORD_W = 16;
    localparam int BUF_W  = 34;
    localparam int REC_W  = 18;

endpackage

// File: rtl/imm_width_select.sv
// Picks the narrowest field (4/8/12/16 bits) that sign-extends back to the
// input value, and reports the resulting record length.
module imm_width_select
    import types_pkg::*;
(
    input  logic [15:0] in_value,
    output sel_t        sel,
    output logic [4:0]  rec_len
);

    // A field of width N fits when bits [15:N-1] are all copies of the sign bit.
    always_comb begin
        sel     = NONE;
        rec_len = REC_LEN_16;
        if ((&in_value[15:3]) || !(|in_value[15:3])) begin
            sel     = FOURBIT;
            rec_len = REC_LEN_4;
        end else if ((&in_value[15:7]) || !(|in_value[15:7])) begin
            sel     = EIGHTBIT;
            rec_len = REC_LEN_8;
        end else if ((&in_value[15:11]) || !(|in_value[15:11])) begin
            sel     = TWELVEBIT;
            rec_len = REC_LEN_12;
        end else begin
            sel     = NONE;
            rec_len = REC_LEN_16;
        end
    end

endmodule

// File: rtl/imm_packer.sv
// Streaming immediate compressor: packs {payload, tag} records LSB-first into
// 16-bit words, with a flush that zero-pads the residual bits to a word.
module imm_packer
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic        flush,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    sel_t              sel_s;
    logic [4:0]        rec_len_s;
    logic [REC_W-1:0]  rec_s;
    logic [BUF_W-1:0]  rec_ext_s;

    pack_state_t       state_r, state_n_s;
    logic [BUF_W-1:0]  buf_r, buf_n_s;
    logic [5:0]        cnt_r, cnt_n_s;
    logic              out_valid_r, out_valid_n_s;
    logic [15:0]       out_data_r, out_data_n_s;
    logic              ready_en_r;
    logic              out_free_s;
    logic              accept_s;
    logic              in_ready_s;

    imm_width_select u_width_select (
        .in_value (in_value),
        .sel      (sel_s),
        .rec_len  (rec_len_s)
    );

    // Assemble the record with the payload truncated to the selected field.
    always_comb begin
        rec_s = {REC_W{1'b0}};
        case (sel_s)
            FOURBIT:   rec_s = {12'd0, in_value[3:0],  2'(FOURBIT)};
            EIGHTBIT:  rec_s = {8'd0,  in_value[7:0],  2'(EIGHTBIT)};
            TWELVEBIT: rec_s = {4'd0,  in_value[11:0], 2'(TWELVEBIT)};
            NONE:      rec_s = {in_value[15:0], 2'(NONE)};
            default:   rec_s = {REC_W{1'b0}};
        endcase
    end

    assign rec_ext_s  = {{(BUF_W-REC_W){1'b0}}, rec_s};
    // ready_en_r keeps in_ready low while reset is asserted.
    assign in_ready_s = ready_en_r && (state_r == PACK) && (cnt_r < 6'd16);
    assign accept_s   = in_valid && in_ready_s;
    assign out_free_s = !out_valid_r || out_ready;

    // Next-state logic: accept, word emission and flush sequencing.
    always_comb begin
        state_n_s     = state_r;
        buf_n_s       = buf_r;
        cnt_n_s       = cnt_r;
        out_valid_n_s = out_valid_r && !out_ready;
        out_data_n_s  = out_data_r;
        case (state_r)
            PACK: begin
                if (accept_s) begin
                    buf_n_s = buf_r | (rec_ext_s << cnt_r);
                    cnt_n_s = cnt_r + {1'b0, rec_len_s};
                end else if (out_free_s && (cnt_r >= 6'd16)) begin
                    out_data_n_s  = buf_r[15:0];
                    out_valid_n_s = 1'b1;
                    buf_n_s       = buf_r >> 16;
                    cnt_n_s       = cnt_r - 6'd16;
                end else begin
                    buf_n_s = buf_r;
                end
                if (flush) begin
                    state_n_s = FLUSH;
                end else begin
                    state_n_s = PACK;
                end
            end
            FLUSH: begin
                if (cnt_r >= 6'd16) begin
                    if (out_free_s) begin
                        out_data_n_s  = buf_r[15:0];
                        out_valid_n_s = 1'b1;
                        buf_n_s       = buf_r >> 16;
                        cnt_n_s       = cnt_r - 6'd16;
                    end else begin
                        buf_n_s = buf_r;
                    end
                end else if (cnt_r == 6'd0) begin
                    state_n_s = PACK;
                end else if (out_free_s) begin
                    // Bits above cnt are always zero, so this is the padded word.
                    out_data_n_s  = buf_r[15:0];
                    out_valid_n_s = 1'b1;
                    buf_n_s       = {BUF_W{1'b0}};
                    cnt_n_s       = 6'd0;
                    state_n_s     = PACK;
                end else begin
                    state_n_s = FLUSH;
                end
            end
            default: begin
                state_n_s = PACK;
            end
        endcase
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= PACK;
            buf_r       <= {BUF_W{1'b0}};
            cnt_r       <= 6'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'd0;
            ready_en_r  <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            buf_r       <= buf_n_s;
            cnt_r       <= cnt_n_s;
            out_valid_r <= out_valid_n_s;
            out_data_r  <= out_data_n_s;
            ready_en_r  <= 1'b1;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = (state_r == FLUSH);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_imm_packer.sv
// Directed and random self-checking bench for imm_packer.
module tb_imm_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int          errors;
    int          checks;
    logic [15:0] words[$];
    int          valid_seen;

    imm_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word collector; inputs only change just after posedge so negedge is stable.
    always @(negedge clk) begin
        if (rst_n && out_valid) valid_seen = valid_seen + 1;
        if (rst_n && out_valid && out_ready) words.push_back(out_data);
    end

    task automatic push(input logic [15:0] v, input bit rnd_bp);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_value = v;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%0b required 1 for value %h", in_ready, v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_value = 16'h0000; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, in_ready, busy} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b data=%h ready=%0b busy=%0b required all 0",
                     out_valid, out_data, in_ready, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_three_neg_one();
        int base;
        base = words.size();
        for (int i = 0; i < 3; i++) push(16'hFFFF, 1'b0);
        pulse_flush();
        idle(8);
        checks++;
        if (words.size() - base !== 2) begin
            errors++;
            $display("FAIL neg1_count: got %0d words required 2", words.size() - base);
        end else begin
            checks++;
            if (words[base] !== 16'hDF7D || words[base+1] !== 16'h0003) begin
                errors++;
                $display("FAIL neg1_words: got %h %h required DF7D 0003", words[base], words[base+1]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL neg1_busy: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_widths();
        logic [15:0] vin [10];
        logic [15:0] w0 [10];
        logic [15:0] w1 [10];
        int          nw [10];
        int          base;
        vin = '{16'h0007, 16'hFFF8, 16'h0008, 16'h007F, 16'hFF80,
                16'h0080, 16'h07FF, 16'hF800, 16'h0800, 16'h8000};
        w0  = '{16'h001D, 16'h0021, 16'h0022, 16'h01FE, 16'h0202,
                16'h0203, 16'h1FFF, 16'h2003, 16'h2000, 16'h0000};
        w1  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002};
        nw  = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
        for (int i = 0; i < 10; i++) begin
            base = words.size();
            push(vin[i], 1'b0);
            pulse_flush();
            idle(8);
            checks++;
            if (words.size() - base !== nw[i]) begin
                errors++;
                $display("FAIL width_count[%h]: got %0d words required %0d", vin[i], words.size() - base, nw[i]);
            end else begin
                checks++;
                if (words[base] !== w0[i] || (nw[i] == 2 && words[base+1] !== w1[i])) begin
                    errors++;
                    $display("FAIL width_word[%h]: got %h required %h (second %h)",
                             vin[i], words[base], w0[i], w1[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int  acc;
        bit  drop_checked;
        int  base;
        base = words.size();
        acc = 0;
        drop_checked = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_value = 16'hFFFF;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (acc == 3 && !drop_checked) begin
                drop_checked = 1'b1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_drop: in_ready=%0b required 0 after 3rd accept", in_ready);
                end
            end
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (acc !== 6 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'hDF7D) begin
            errors++;
            $display("FAIL bp_hold: acc=%0d ready=%0b valid=%0b data=%h required 6 0 1 DF7D",
                     acc, in_ready, out_valid, out_data);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(8);
        checks++;
        if (words.size() - base !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d words required 3", words.size() - base);
        end else begin
            checks++;
            if (words[base] !== 16'hDF7D || words[base+1] !== 16'h7DF7 || words[base+2] !== 16'hF7DF) begin
                errors++;
                $display("FAIL bp_words: got %h %h %h required DF7D 7DF7 F7DF",
                         words[base], words[base+1], words[base+2]);
            end
        end
    endtask

    task automatic test_empty_flush();
        int vbase;
        vbase = valid_seen;
        pulse_flush();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_flush_busy: busy=%0b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_flush_done: busy=%0b required 0", busy);
        end
        idle(4);
        checks++;
        if (valid_seen !== vbase) begin
            errors++;
            $display("FAIL empty_flush_valid: saw %0d valid cycles required 0", valid_seen - vbase);
        end
    endtask

    task automatic test_mid_reset();
        int vbase;
        push(16'h0003, 1'b0);
        push(16'hFFFE, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_data, in_ready, busy} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: valid=%0b data=%h ready=%0b busy=%0b required all 0",
                     out_valid, out_data, in_ready, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        vbase = valid_seen;
        pulse_flush();
        idle(6);
        checks++;
        if (valid_seen !== vbase) begin
            errors++;
            $display("FAIL mid_reset_flush: saw %0d valid cycles required 0", valid_seen - vbase);
        end
    endtask

    function automatic logic [15:0] sext(input logic [15:0] p, input logic [1:0] tag);
        case (tag)
            2'b01:   return {{12{p[3]}}, p[3:0]};
            2'b10:   return {{8{p[7]}}, p[7:0]};
            2'b11:   return {{4{p[11]}}, p[11:0]};
            default: return p;
        endcase
    endfunction

    task automatic test_round_trip();
        logic [15:0] sent[$];
        logic        bits[$];
        logic [15:0] v;
        logic [15:0] p;
        logic [1:0]  tag;
        int          r;
        int          base;
        int          pos;
        int          len;
        int          got;
        base = words.size();
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       r = int'($urandom_range(0, 15)) - 8;
                1:       r = int'($urandom_range(0, 255)) - 128;
                2:       r = int'($urandom_range(0, 4095)) - 2048;
                default: r = int'($urandom_range(0, 65535));
            endcase
            v = r[15:0];
            sent.push_back(v);
            push(v, 1'b1);
        end
        out_ready = 1'b1;
        idle(4);
        pulse_flush();
        idle(10);
        for (int w = base; w < words.size(); w++)
            for (int j = 0; j < 16; j++) bits.push_back(words[w][j]);
        pos = 0;
        got = 0;
        while (got < sent.size() && pos + 2 <= bits.size()) begin
            tag = {bits[pos+1], bits[pos]};
            len = (tag == 2'b01) ? 4 : (tag == 2'b10) ? 8 : (tag == 2'b11) ? 12 : 16;
            if (pos + 2 + len > bits.size()) break;
            p = 16'h0000;
            for (int j = 0; j < len; j++) p[j] = bits[pos+2+j];
            pos = pos + 2 + len;
            checks++;
            if (sext(p, tag) !== sent[got]) begin
                errors++;
                $display("FAIL round_trip[%0d]: got %h required %h", got, sext(p, tag), sent[got]);
            end
            got++;
        end
        checks++;
        if (got !== sent.size()) begin
            errors++;
            $display("FAIL round_trip_count: decoded %0d values required %0d", got, sent.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        valid_seen = 0;
        test_reset();
        test_three_neg_one();
        test_widths();
        test_backpressure();
        test_empty_flush();
        test_mid_reset();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
